dm_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 128x32 data memory `dm` between the CPU MEM stage (master 0) and a debug/loader port (master 1). Grants at most one access per cycle, drives the `dm` port (`addr`, `rd`, `wr`, `wdata`), and returns read data with a per-master valid strobe. Supports a lock for atomic read-modify-write sequences with a bounded lock timeout. Sits between the pipeline/debug logic and the `dm` instance.

---
 rtl/dm_arb_pkg.sv | 20 ++
 rtl/dm_arb_lock_timer.sv | 23 ++
 rtl/dm_arbiter.sv | 105 ++++++++++
 tb/tb_dm_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared defaults, FSM state type and master request bundle for dm_arbiter.
//   DM_AW / DM_DW  default word-address and data widths of the 128x32 data memory
//   dm_arb_state_t IDLE, LOCK0 (master 0 owns the memory), LOCK1 (master 1 owns it)
//   dm_arb_req_t   one master's request bundle (req, we, lock, addr, wdata)
package dm_arb_pkg;
  localparam int DM_AW = 7;
  localparam int DM_DW = 32;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } dm_arb_state_t;
  typedef struct packed {
    logic             req;
    logic             we;
    logic             lock;
    logic [DM_AW-1:0] addr;
    logic [DM_DW-1:0] wdata;
  } dm_arb_req_t;
endpackage

// File: rtl/dm_arb_lock_timer.sv
// dm_arb_lock_timer: counts cycles a lock has been held and flags the forced-release cycle.
//   clk, rst  clock and synchronous active-high reset
//   i_clr     lock entered this cycle; restart the count
//   i_run     arbiter currently in a locked state
//   o_exp     this locked cycle is the LOCK_MAX-th since lock entry; lock must be released
module dm_arb_lock_timer #(
  parameter int LOCK_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_run,
  output logic o_exp
);
  localparam int CW = $clog2(LOCK_MAX);
  // r_cnt holds locked cycles already completed, so it reads LOCK_MAX-1 in the LOCK_MAX-th one
  logic [CW-1:0] r_cnt;
  assign o_exp = i_run && (r_cnt == CW'(LOCK_MAX - 1));
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_run && !o_exp) r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master arbiter for the single-port data memory with lock and lock timeout.
//   clk, rst                     clock, synchronous active-high reset
//   mN_req/we/addr/wdata/lock    master N request (0 = CPU MEM stage, 1 = debug/loader)
//   mN_gnt                       access accepted this cycle (combinational)
//   mN_rvalid / mN_rdata         read data for master N, one cycle after its read grant
//   dm_addr/rd/wr/wdata          memory port; addr/wdata hold their last value when idle
//   dm_rdata                     memory read data, valid the cycle after dm_rd
// Build option: define DM_ARB_RR_EN for round-robin contention; default is fixed priority
// to master 0.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW       = DM_AW,
  parameter int DW       = DM_DW,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] dm_addr,
  output logic          dm_rd,
  output logic          dm_wr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata
);
  dm_arb_state_t r_state, w_state_nxt;
  logic          w_exp, w_open, w_owner, w_pri, w_g0, w_g1, w_entry;
  logic          r_pri, r_rv0, r_rv1;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  dm_arb_lock_timer #(.LOCK_MAX(LOCK_MAX)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_entry),
    .i_run (r_state != IDLE),
    .o_exp (w_exp)
  );

  // An expiring lock arbitrates like IDLE in the same cycle, favouring the non-owner.
  assign w_owner = (r_state == LOCK1);
  assign w_open  = (r_state == IDLE) || w_exp;
  assign w_pri   = w_exp ? ~w_owner : r_pri;
  assign w_g0    = !rst && m0_req && (w_open ? (!m1_req || !w_pri) : (r_state == LOCK0));
  assign w_g1    = !rst && m1_req && (w_open ? (!m0_req ||  w_pri) : (r_state == LOCK1));
  assign w_entry = w_open && ((w_g0 && m0_lock) || (w_g1 && m1_lock));
  assign w_state_nxt = w_g0  ? (m0_lock ? LOCK0 : IDLE) :
                       w_g1  ? (m1_lock ? LOCK1 : IDLE) :
                       w_exp ? IDLE : r_state;

  assign m0_gnt    = w_g0;
  assign m1_gnt    = w_g1;
  assign m0_rvalid = r_rv0 && !rst;
  assign m1_rvalid = r_rv1 && !rst;
  assign m0_rdata  = dm_rdata;
  assign m1_rdata  = dm_rdata;
  assign dm_rd     = (w_g0 && !m0_we) || (w_g1 && !m1_we);
  assign dm_wr     = (w_g0 &&  m0_we) || (w_g1 &&  m1_we);
  assign dm_addr   = rst ? '0 : w_g0 ? m0_addr  : w_g1 ? m1_addr  : r_addr;
  assign dm_wdata  = rst ? '0 : w_g0 ? m0_wdata : w_g1 ? m1_wdata : r_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rv0   <= w_g0 && !m0_we;
      r_rv1   <= w_g1 && !m1_we;
      r_addr  <= dm_addr;
      r_wdata <= dm_wdata;
    end
  end

  // r_pri names the master that wins the next contention. Round-robin points it away from
  // the last grantee; fixed priority keeps it at 0 except for one arbitration after a
  // forced release.
  always_ff @(posedge clk) begin
    if (rst) r_pri <= 1'b0;
`ifdef DM_ARB_RR_EN
    else if (w_g0 || w_g1) r_pri <= w_g0;
`else
    else if (w_g0 || w_g1) r_pri <= 1'b0;
`endif
    else if (w_exp) r_pri <= ~w_owner;
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized and directed checks of dm_arbiter against a behavioural model.
module tb_dm_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int LOCK_MAX = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
  logic          m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] dm_addr;
  logic          dm_rd, dm_wr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata = '0;
  logic [DW-1:0] mem [128] = '{default: '0};

  int n_chk = 0;
  int n_err = 0;

  dm_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_lock   (m0_lock),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_lock   (m1_lock),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .dm_addr   (dm_addr),
    .dm_rd     (dm_rd),
    .dm_wr     (dm_wr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata)
  );

  always #5 clk = ~clk;

  // the single-port memory itself: registered read, data valid the cycle after dm_rd
  always @(posedge clk) begin
    if (dm_wr) mem[dm_addr] <= dm_wdata;
    if (dm_rd) dm_rdata <= mem[dm_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // behavioural model: who owns the memory, how long the lock has been held,
  // who wins the next contention, and a shadow copy of the memory contents
  int          owner = -1;
  int          age = 0;
  int          pref = 0;
  int          win, fav, prev_owner;
  bit          expd, open;
  bit          rq [2], wq [2], lq [2];
  int          ad [2];
  logic [31:0] wd [2];
  bit          rv [2] = '{0, 0};
  logic [31:0] rvd [2] = '{0, 0};
  int          last_addr = 0;
  logic [31:0] last_wdata = '0;
  logic [31:0] shadow [128] = '{default: '0};

  always @(negedge clk) begin
    rq[0] = m0_req; wq[0] = m0_we; lq[0] = m0_lock; ad[0] = int'(m0_addr); wd[0] = m0_wdata;
    rq[1] = m1_req; wq[1] = m1_we; lq[1] = m1_lock; ad[1] = int'(m1_addr); wd[1] = m1_wdata;
    expd = !rst && owner >= 0 && age == LOCK_MAX;
    open = owner < 0 || expd;
    fav  = expd ? 1 - owner : pref;
    win  = -1;
    if (!rst) begin
      if (open) win = (rq[0] && rq[1]) ? fav : rq[0] ? 0 : rq[1] ? 1 : -1;
      else if (rq[owner]) win = owner;
    end
    chk("m0_gnt", m0_gnt, win == 0);
    chk("m1_gnt", m1_gnt, win == 1);
    chk("dm_rd", dm_rd, win >= 0 ? !wq[win] : 0);
    chk("dm_wr", dm_wr, win >= 0 ? wq[win] : 0);
    chk("dm_addr", dm_addr, rst ? 0 : win >= 0 ? ad[win] : last_addr);
    chk("dm_wdata", dm_wdata, rst ? 0 : win >= 0 ? wd[win] : last_wdata);
    chk("m0_rvalid", m0_rvalid, !rst && rv[0]);
    chk("m1_rvalid", m1_rvalid, !rst && rv[1]);
    if (!rst && rv[0]) chk("m0_rdata", m0_rdata, rvd[0]);
    if (!rst && rv[1]) chk("m1_rdata", m1_rdata, rvd[1]);
    chk("rd_wr_excl", dm_rd & dm_wr, 0);
    if (rst) begin
      owner = -1; age = 0; pref = 0; rv = '{0, 0}; last_addr = 0; last_wdata = '0;
    end else begin
      rv[0] = win == 0 && !wq[0];
      rv[1] = win == 1 && !wq[1];
      prev_owner = owner;
      if (win >= 0) begin
        last_addr = ad[win];
        last_wdata = wd[win];
        if (wq[win]) shadow[ad[win]] = wd[win];
        else rvd[win] = shadow[ad[win]];
      end
      if (win >= 0 && open) begin
        owner = lq[win] ? win : -1;
        age = 1;
      end else if (win >= 0) begin
        if (!lq[win]) owner = -1;
        else age++;
      end else if (expd) owner = -1;
      else if (owner >= 0) age++;
`ifdef DM_ARB_RR_EN
      if (win >= 0) pref = 1 - win;
`else
      if (win >= 0) pref = 0;
`endif
      else if (expd) pref = 1 - prev_owner;
    end
  end

  bit prev_g1;
  int rq_p, lk_p;

  initial begin
    tick;
    tick;
    @(negedge clk);
    chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
    chk("rst_rdwr", {dm_rd, dm_wr}, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    tick;
    rst = 0;
    // single master write then read
    m0_req = 1; m0_we = 1; m0_addr = 5; m0_wdata = 10;
    @(negedge clk);
    chk("sm_wr_gnt", m0_gnt, 1);
    chk("sm_wr", dm_wr, 1);
    chk("sm_wr_addr", dm_addr, 5);
    tick;
    m0_we = 0;
    @(negedge clk);
    chk("sm_rd_gnt", m0_gnt, 1);
    chk("sm_rd", dm_rd, 1);
    tick;
    m0_req = 0;
    @(negedge clk);
    chk("sm_rvalid", m0_rvalid, 1);
    chk("sm_rdata", m0_rdata, 10);
    chk("sm_m1_rvalid", m1_rvalid, 0);
    chk("sm_hold_addr", dm_addr, 5);
    // lock: m1 read-modify-write at 20 while m0 waits
    tick;
    m1_req = 1; m1_we = 0; m1_addr = 20; m1_lock = 1;
    @(negedge clk);
    chk("lk_m1_gnt", m1_gnt, 1);
    tick;
    m1_req = 0; m0_req = 1; m0_we = 0; m0_addr = 20;
    @(negedge clk);
    chk("lk_m0_blocked", m0_gnt, 0);
    tick;
    m1_req = 1; m1_we = 1; m1_wdata = 32'h1234; m1_lock = 0;
    @(negedge clk);
    chk("lk_m1_wr_gnt", m1_gnt, 1);
    chk("lk_m0_blocked2", m0_gnt, 0);
    tick;
    m1_req = 0;
    @(negedge clk);
    chk("lk_m0_gnt", m0_gnt, 1);
    tick;
    m0_req = 0;
    @(negedge clk);
    chk("lk_m0_rvalid", m0_rvalid, 1);
    chk("lk_m0_rdata", m0_rdata, 32'h1234);
    // lock timeout: m0 locks and goes quiet, m1 waits
    tick;
    m0_req = 1; m0_we = 1; m0_addr = 30; m0_wdata = 7; m0_lock = 1;
    @(negedge clk);
    chk("to_lock_gnt", m0_gnt, 1);
    tick;
    m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 30;
    for (int k = 1; k <= LOCK_MAX; k++) begin
      @(negedge clk);
      chk($sformatf("to_m1_gnt_%0d", k), m1_gnt, k == LOCK_MAX);
      tick;
    end
    m1_req = 0; m0_lock = 0;
    @(negedge clk);
    chk("to_m1_rvalid", m1_rvalid, 1);
    chk("to_m1_rdata", m1_rdata, 7);
    // reset in LOCK0 with a read in flight
    tick;
    m0_req = 1; m0_we = 0; m0_addr = 5; m0_lock = 1;
    tick;
    @(negedge clk);
    chk("rl_m0_gnt", m0_gnt, 1);
    tick;
    rst = 1; m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 5;
    @(negedge clk);
    chk("rl_m0_rvalid", m0_rvalid, 0);
    chk("rl_m1_gnt", m1_gnt, 0);
    chk("rl_rd", dm_rd, 0);
    chk("rl_addr", dm_addr, 0);
    tick;
    rst = 0;
    @(negedge clk);
    chk("rl_m1_first", m1_gnt, 1);
    chk("rl_m0_rvalid2", m0_rvalid, 0);
    tick;
    m1_req = 0; m0_lock = 0;
    @(negedge clk);
    chk("rl_m1_rdata", m1_rdata, 10);
    // contention: both request every cycle
    tick;
    m0_req = 1; m0_we = 1; m0_addr = 10; m0_wdata = 99;
    m1_req = 1; m1_we = 0; m1_addr = 10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef DM_ARB_RR_EN
      chk("ct_one_gnt", m0_gnt ^ m1_gnt, 1);
      if (i > 0) chk("ct_alternate", m1_gnt, !prev_g1);
      prev_g1 = m1_gnt;
`else
      chk("ct_m0_wins", m0_gnt, 1);
      chk("ct_m1_starves", m1_gnt, 0);
`endif
      tick;
    end
    m0_req = 0; m1_req = 0;
    // sweep: m0 writes k*5 <- k*10, m1 reads it back
    for (int k = 1; k <= 25; k++) begin
      m0_req = 1; m0_we = 1; m0_addr = AW'(k * 5); m0_wdata = DW'(k * 10); m1_req = 0;
      @(negedge clk);
      chk("sw_wr_gnt", m0_gnt, 1);
      tick;
      m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = AW'(k * 5);
      @(negedge clk);
      chk("sw_rd_gnt", m1_gnt, 1);
      tick;
      m1_req = 0;
      @(negedge clk);
      chk("sw_rvalid", m1_rvalid, 1);
      chk("sw_rdata", m1_rdata, k * 10);
      tick;
    end
    // randomized segments with varying request and lock density
    for (int s = 0; s < 50; s++) begin
      rq_p = $urandom_range(1, 3);
      lk_p = $urandom_range(0, 2);
      for (int c = 0; c < 60; c++) begin
        rst      = ($urandom_range(299) == 0);
        m0_req   = ($urandom_range(3) < rq_p);
        m1_req   = ($urandom_range(3) < rq_p);
        m0_we    = $urandom_range(1);
        m1_we    = $urandom_range(1);
        m0_lock  = ($urandom_range(3) < lk_p);
        m1_lock  = ($urandom_range(3) < lk_p);
        m0_addr  = AW'($urandom_range(127));
        m1_addr  = AW'($urandom_range(127));
        m0_wdata = $urandom;
        m1_wdata = $urandom;
        tick;
      end
    end
    rst = 0; m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
    repeat (3) tick;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
